// File: rtl/sevenseg_scan_n_if.sv
// sevenseg_scan_n_if -- signal bundle between a register source and the
// seven-segment scan driver. The source (master) presents a packed hex value
// with per-digit decimal points and blanking plus a load strobe. The driver
// (slave) returns the active-low segment, decimal-point and anode lines and a
// scan-advance pulse.
interface sevenseg_scan_n_if #(
    parameter int NDIGITS = 8
);
    logic                   load;
    logic [4*NDIGITS-1:0]   data;
    logic [NDIGITS-1:0]     dp_in;
    logic [NDIGITS-1:0]     blank_in;
    logic [6:0]             segs_n;
    logic                   dp_n;
    logic [NDIGITS-1:0]     an_n;
    logic                   digit_tick;

    modport master (
        output load, data, dp_in, blank_in,
        input  segs_n, dp_n, an_n, digit_tick
    );

    modport slave (
        input  load, data, dp_in, blank_in,
        output segs_n, dp_n, an_n, digit_tick
    );
endinterface

// File: rtl/sevenseg_scan_n.sv
// sevenseg_scan_n -- time-multiplexed N-digit hex seven-segment driver for a
// common-anode display. Segment, decimal-point and anode outputs are all
// active low. Each digit slot lasts DIV_COUNT clocks. The first clock of a
// slot is a guard cycle with every anode off, so the previous digit's
// segments never ghost onto the next anode.
//
// Optional feature: define SEVENSEG_LZ_BLANK_EN to suppress leading zeros.
// Digits above the most-significant non-zero nibble are darkened unless their
// decimal point is set. Digit 0 is never suppressed.
//
// The NDIGITS parameter must match the NDIGITS of the connected interface.
module sevenseg_scan_n #(
    parameter  int NDIGITS   = 8,
    parameter  int DIV_COUNT = 100000,
    localparam int IDX_W     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sevenseg_scan_n_if.slave     bus
);

    localparam int PRE_W = $clog2(DIV_COUNT);

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } slot_phase_e;

    logic [PRE_W-1:0]       r_presc;
    logic [IDX_W-1:0]       r_idx;
    logic [4*NDIGITS-1:0]   r_shadowData;
    logic [NDIGITS-1:0]     r_shadowDp;
    logic [NDIGITS-1:0]     r_shadowBlank;

    logic [6:0]             r_segsN;
    logic                   r_dpN;
    logic [NDIGITS-1:0]     r_anN;
    logic                   r_digitTick;

    logic                   w_prescLast;
    slot_phase_e            w_phase;
    logic [NDIGITS-1:0]     w_lzMask;
    logic [NDIGITS-1:0]     w_blankMask;
    logic [3:0]             w_nibble;
    logic                   w_dpBit;
    logic                   w_blankBit;
    logic [NDIGITS-1:0]     w_anDrive;
    logic [6:0]             w_segsDecoded;
    logic [6:0]             w_segsNext;
    logic                   w_dpNext;
    logic [NDIGITS-1:0]     w_anNext;

    assign w_prescLast = (r_presc == PRE_W'(DIV_COUNT - 1));

    // Prescaler sets the slot length; the digit index advances as the prescaler wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_prescLast) begin
            r_presc <= '0;
            if (r_idx == IDX_W'(NDIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Shadow registers hold the displayed value and only change on a load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadowData  <= '0;
            r_shadowDp    <= '0;
            r_shadowBlank <= '0;
        end else if (bus.load) begin
            r_shadowData  <= bus.data;
            r_shadowDp    <= bus.dp_in;
            r_shadowBlank <= bus.blank_in;
        end
    end

    // The first prescaler count of each slot is the anode guard cycle.
    always_comb begin
        w_phase = (r_presc == '0) ? GUARD : DRIVE;
    end

`ifdef SEVENSEG_LZ_BLANK_EN
    // Walk down from the top digit, darkening zeros until the first non-zero nibble.
    always_comb begin
        logic seenNonZero;
        seenNonZero = 1'b0;
        w_lzMask    = '0;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            if (r_shadowData[4*i +: 4] != 4'h0) begin
                seenNonZero = 1'b1;
            end
            if (!seenNonZero && !r_shadowDp[i]) begin
                w_lzMask[i] = 1'b1;
            end
        end
    end
`else
    // Without leading-zero suppression only the explicit blank bits darken digits.
    always_comb begin
        w_lzMask = '0;
    end
`endif

    assign w_blankMask = r_shadowBlank | w_lzMask;

    // Select the nibble, decimal point, blank flag and anode pattern for the current index.
    always_comb begin
        w_nibble   = 4'h0;
        w_dpBit    = 1'b0;
        w_blankBit = 1'b0;
        w_anDrive  = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble     = r_shadowData[4*i +: 4];
                w_dpBit      = r_shadowDp[i];
                w_blankBit   = w_blankMask[i];
                w_anDrive[i] = 1'b0;
            end
        end
    end

    // Hex to active-low segment decode, gfedcba order.
    always_comb begin
        w_segsDecoded = 7'b1111111;
        case (w_nibble)
            4'h0: w_segsDecoded = 7'b1000000;
            4'h1: w_segsDecoded = 7'b1111001;
            4'h2: w_segsDecoded = 7'b0100100;
            4'h3: w_segsDecoded = 7'b0110000;
            4'h4: w_segsDecoded = 7'b0011001;
            4'h5: w_segsDecoded = 7'b0010010;
            4'h6: w_segsDecoded = 7'b0000010;
            4'h7: w_segsDecoded = 7'b1111000;
            4'h8: w_segsDecoded = 7'b0000000;
            4'h9: w_segsDecoded = 7'b0010000;
            4'hA: w_segsDecoded = 7'b0001000;
            4'hB: w_segsDecoded = 7'b0000011;
            4'hC: w_segsDecoded = 7'b1000110;
            4'hD: w_segsDecoded = 7'b0100001;
            4'hE: w_segsDecoded = 7'b0000110;
            4'hF: w_segsDecoded = 7'b0001110;
            default: w_segsDecoded = 7'b1111111;
        endcase
    end

    // Next output values: everything dark in GUARD; in DRIVE one anode low, blanked digits dark.
    always_comb begin
        w_segsNext = 7'b1111111;
        w_dpNext   = 1'b1;
        w_anNext   = '1;
        if (w_phase == DRIVE) begin
            w_anNext = w_anDrive;
            if (!w_blankBit) begin
                w_segsNext = w_segsDecoded;
                w_dpNext   = ~w_dpBit;
            end
        end
    end

    // Register every output so the display lines are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segsN     <= 7'b1111111;
            r_dpN       <= 1'b1;
            r_anN       <= '1;
            r_digitTick <= 1'b0;
        end else begin
            r_segsN     <= w_segsNext;
            r_dpN       <= w_dpNext;
            r_anN       <= w_anNext;
            r_digitTick <= w_prescLast;
        end
    end

    assign bus.segs_n     = r_segsN;
    assign bus.dp_n       = r_dpN;
    assign bus.an_n       = r_anN;
    assign bus.digit_tick = r_digitTick;

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// tb_sevenseg_scan_n -- self-checking bench for sevenseg_scan_n with
// NDIGITS = 4 and DIV_COUNT = 4. Expected outputs come from a cycle-count
// model. After e clock edges since reset release, the outputs describe
// prescaler slot (e-1) mod 4 of digit ((e-1)/4) mod 4, using the value loaded
// before that edge. digit_tick is high whenever e is a multiple of 4.
module tb_sevenseg_scan_n;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam logic [12:0] RESET_OUT = {1'b0, 1'b1, 4'b1111, 7'b1111111};

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int edges;

    logic [15:0] mData;
    logic [3:0]  mDp;
    logic [3:0]  mBlank;

    sevenseg_scan_n_if #(.NDIGITS(N)) bus ();

    sevenseg_scan_n #(
        .NDIGITS   (N),
        .DIV_COUNT (DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected packed output {tick, dp_n, an_n, segs_n} after edge e.
    function automatic logic [12:0] modelOut(input int e, input logic [15:0] d,
                                             input logic [3:0] dp, input logic [3:0] bl);
        int         slot;
        int         idx;
        logic       tick;
        logic       dark;
        logic [3:0] an;
        logic [3:0] nib;
        if (e == 0) return RESET_OUT;
        slot = (e - 1) % DIV;
        idx  = ((e - 1) / DIV) % N;
        tick = ((e % DIV) == 0);
        if (slot == 0) return {tick, 1'b1, 4'b1111, 7'b1111111};
        an   = ~(4'b0001 << idx);
        nib  = 4'((d >> (4 * idx)) & 16'hF);
        dark = bl[idx];
`ifdef SEVENSEG_LZ_BLANK_EN
        if (idx != 0 && (d >> (4 * idx)) == 16'h0 && !dp[idx]) dark = 1'b1;
`endif
        if (dark) return {tick, 1'b1, an, 7'b1111111};
        return {tick, ~dp[idx], an, SEG_TABLE[nib]};
    endfunction

    function automatic logic [12:0] packedOut();
        return {bus.digit_tick, bus.dp_n, bus.an_n, bus.segs_n};
    endfunction

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
        end
    endtask

    // Present a set of load-side inputs to the driver.
    task automatic applyStimulus(input logic ld, input logic [15:0] d,
                                 input logic [3:0] dp, input logic [3:0] bl);
        bus.load     = ld;
        bus.data     = d;
        bus.dp_in    = dp;
        bus.blank_in = bl;
    endtask

    // Advance one clock edge, update the model and compare the outputs 1 ns later.
    task automatic stepCycle(input string tag);
        logic [12:0] expOut;
        @(posedge clk);
        if (!rst_n) begin
            expOut = RESET_OUT;
        end else begin
            edges++;
            expOut = modelOut(edges, mData, mDp, mBlank);
            if (bus.load) begin
                mData  = bus.data;
                mDp    = bus.dp_in;
                mBlank = bus.blank_in;
            end
        end
        #1;
        checkOutput(tag, 32'(packedOut()), 32'(expOut));
    endtask

    task automatic runCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) stepCycle(tag);
    endtask

    task automatic loadOnce(input string tag, input logic [15:0] d,
                            input logic [3:0] dp, input logic [3:0] bl);
        applyStimulus(1'b1, d, dp, bl);
        stepCycle(tag);
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic modelReset();
        edges  = 0;
        mData  = '0;
        mDp    = '0;
        mBlank = '0;
    endtask

    initial begin
        logic [15:0] rd;
        checks = 0;
        errors = 0;
        modelReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0);

        // Reset held for three cycles.
        runCycles("reset_hold", 3);
        rst_n = 1'b1;

        // Idle scan of the all-zero reset value.
        runCycles("idle_scan", 8);

        // Plain scan of 3A5F.
        loadOnce("scan_load", 16'h3A5F, 4'h0, 4'h0);
        runCycles("scan_3A5F", 20);

        // Blank digit 2, decimal point on digit 0.
        loadOnce("blank_dp_load", 16'h3A5F, 4'b0001, 4'b0100);
        runCycles("blank_dp", 16);

        // Align so that the next edge moves the index from 0 to 1, then load on that edge.
        for (int i = 0; i < 4 * DIV; i++) begin
            if ((edges % DIV) == DIV - 1 && ((edges / DIV) % N) == 0) break;
            stepCycle("align_collision");
        end
        loadOnce("collision_load", 16'h0007, 4'h0, 4'h0);
        runCycles("collision", 20);

        // Assert reset between edges while digit 2 is being driven.
        for (int i = 0; i < 4 * DIV; i++) begin
            if ((edges % DIV) == 2 && ((edges / DIV) % N) == 2) break;
            stepCycle("align_async");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'(packedOut()), 32'(RESET_OUT));
        modelReset();
        runCycles("async_hold", 2);
        #2;
        rst_n = 1'b1;
        runCycles("restart_scan", 12);

        // Leading-zero cases; the model covers both builds.
        loadOnce("lz_load", 16'h0042, 4'h0, 4'h0);
        runCycles("lz_0042", 16);
        loadOnce("lz_zero_load", 16'h0000, 4'h0, 4'h0);
        runCycles("lz_0000", 16);
        loadOnce("lz_dp_load", 16'h0005, 4'b1000, 4'h0);
        runCycles("lz_dp", 16);

        // Randomized loads, including held-high load and values with zero upper nibbles.
        for (int i = 0; i < 400; i++) begin
            rd = 16'($urandom >> (4 * $urandom_range(0, 4)));
            applyStimulus(($urandom_range(0, 3) == 0), rd, 4'($urandom),
                          4'($urandom & $urandom));
            stepCycle("random");
        end
        applyStimulus(1'b0, 16'h0, 4'h0, 4'h0);
        runCycles("random_tail", 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
